issue_unit: RTL and testbench

Issue scheduler for the out-of-order back end. Each cycle it selects at most one ready reservation station (integer, load/store, multiply, divide) to issue to its functional unit. It guarantees that no two issued operations write the common data bus (CDB) in the same cycle, and it enforces the non-pipelined divider's occupancy. It sits between the dispatcher's reservation stations and the execution units, and replaces the `tb_*_rd` strobes currently driven by the testbench.

---
 rtl/riscv_sp_pkg.sv | 14 +
 rtl/cdb_rsv_shreg.sv | 24 ++
 rtl/issue_unit.sv | 115 +++++++++++
 tb/tb_issue_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_sp_pkg.sv
// Shared back-end types: functional-unit encoding and default execution latencies.
package riscv_sp_pkg;

  typedef enum logic [1:0] {
    FU_INT   = 2'd0,
    FU_LD_SW = 2'd1,
    FU_MULT  = 2'd2,
    FU_DIV   = 2'd3
  } fu_e;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 7;

endpackage

// File: rtl/cdb_rsv_shreg.sv
// CDB reservation shift register: bit k set means the bus is owned k+1 cycles from now.
// New reservations are OR-ed in before the shift, so a set at bit n lands in bit n-1 next cycle.
module cdb_rsv_shreg #(
  parameter int WIDTH = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] set_mask,
  output logic [WIDTH-1:0] rsv
);

  logic [WIDTH-1:0] rsv_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rsv_reg <= '0;
    end else begin
      rsv_reg <= (rsv_reg | set_mask) >> 1;
    end
  end

  assign rsv = rsv_reg;

endmodule

// File: rtl/issue_unit.sv
// Single-issue scheduler: picks one eligible reservation station per cycle, avoiding CDB
// write collisions and honouring divider occupancy. Define ISSUE_LRU_EN for int/ld_sw alternation.
module issue_unit
  import riscv_sp_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               int_ready,
  input  logic               ld_sw_ready,
  input  logic               mult_ready,
  input  logic               div_ready,
  output logic               int_rd,
  output logic               ld_sw_rd,
  output logic               mult_rd,
  output logic               div_rd,
  output logic               issue_valid,
  output logic [1:0]         issue_fu,
  output logic               div_busy,
  output logic [DIV_LAT-1:0] cdb_rsv
);

  localparam int CNT_W = $clog2(DIV_LAT);

  logic [CNT_W-1:0]   div_cnt_reg;
  logic [DIV_LAT-1:0] set_mask;
  logic               div_elig;
  logic               mult_elig;
  logic               int_elig;
  logic               ld_sw_elig;
  logic               grant_lo;
  logic               prefer_ld_sw;
  fu_e                fu_sel;

  assign div_busy = (div_cnt_reg != '0);

  // Eligibility looks at the slot each unit would write the CDB in.
  assign div_elig   = div_ready & ~div_busy & ~cdb_rsv[DIV_LAT-1];
  assign mult_elig  = mult_ready & ~cdb_rsv[MULT_LAT-1];
  assign int_elig   = int_ready & ~cdb_rsv[0];
  assign ld_sw_elig = ld_sw_ready & ~cdb_rsv[0];

  // Strobes pop reservation stations, so they must stay low while reset is asserted.
  assign div_rd   = i_rst_n & div_elig;
  assign mult_rd  = i_rst_n & ~div_elig & mult_elig;
  assign grant_lo = i_rst_n & ~div_elig & ~mult_elig;
  assign int_rd   = grant_lo & int_elig & (~ld_sw_elig | ~prefer_ld_sw);
  assign ld_sw_rd = grant_lo & ld_sw_elig & (~int_elig | prefer_ld_sw);

  assign issue_valid = int_rd | ld_sw_rd | mult_rd | div_rd;

  always_comb begin
    fu_sel = FU_INT;
    if (div_rd) begin
      fu_sel = FU_DIV;
    end else if (mult_rd) begin
      fu_sel = FU_MULT;
    end else if (ld_sw_rd) begin
      fu_sel = FU_LD_SW;
    end
  end

  assign issue_fu = fu_sel;

`ifdef ISSUE_LRU_EN
  logic lru_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lru_reg <= 1'b0;
    end else if (int_rd) begin
      lru_reg <= 1'b1;
    end else if (ld_sw_rd) begin
      lru_reg <= 1'b0;
    end
  end

  assign prefer_ld_sw = lru_reg;
`else
  assign prefer_ld_sw = 1'b0;
`endif

  // Divider is not pipelined: block further divides until the counter drains.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      div_cnt_reg <= '0;
    end else if (div_rd) begin
      div_cnt_reg <= CNT_W'(DIV_LAT - 1);
    end else if (div_busy) begin
      div_cnt_reg <= div_cnt_reg - 1'b1;
    end
  end

  always_comb begin
    set_mask = '0;
    if (mult_rd) begin
      set_mask[MULT_LAT-1] = 1'b1;
    end
    if (div_rd) begin
      set_mask[DIV_LAT-1] = 1'b1;
    end
  end

  cdb_rsv_shreg #(
    .WIDTH(DIV_LAT)
  ) u_cdb_rsv_shreg (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .set_mask (set_mask),
    .rsv      (cdb_rsv)
  );

endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: directed scenarios plus a randomized run against
// an absolute-time CDB booking model. Strobe vectors are ordered {div, mult, ld_sw, int}.
module tb_issue_unit;
  import riscv_sp_pkg::*;

  localparam int ML = MULT_LAT_DEF;
  localparam int DL = DIV_LAT_DEF;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          int_ready, ld_sw_ready, mult_ready, div_ready;
  logic          int_rd, ld_sw_rd, mult_rd, div_rd;
  logic          issue_valid, div_busy;
  logic [1:0]    issue_fu;
  logic [DL-1:0] cdb_rsv;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]    strb;
    logic          busy;
    logic [DL-1:0] rsv;
  } exp_t;

  exp_t sb[$];

  always #5 i_clk = ~i_clk;

  issue_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .int_ready   (int_ready),
    .ld_sw_ready (ld_sw_ready),
    .mult_ready  (mult_ready),
    .div_ready   (div_ready),
    .int_rd      (int_rd),
    .ld_sw_rd    (ld_sw_rd),
    .mult_rd     (mult_rd),
    .div_rd      (div_rd),
    .issue_valid (issue_valid),
    .issue_fu    (issue_fu),
    .div_busy    (div_busy),
    .cdb_rsv     (cdb_rsv)
  );

  function automatic logic [3:0] strobes();
    return {div_rd, mult_rd, ld_sw_rd, int_rd};
  endfunction

  task automatic set_rdy(input logic [3:0] r);
    {div_ready, mult_ready, ld_sw_ready, int_ready} = r;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    set_rdy(4'h0);
    next_cycle();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    i_rst_n = 1'b0;
    set_rdy(4'hF);
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      sb.push_back('{strb: 4'b0000, busy: 1'b0, rsv: '0});
      #2;
      e = sb.pop_front();
      checks++;
      if (strobes() !== e.strb || issue_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_strobes c%0d got=%b valid=%b exp=%b", c, strobes(), issue_valid, e.strb);
      end
      checks++;
      if (cdb_rsv !== e.rsv || div_busy !== e.busy) begin
        errors++;
        $display("FAIL reset_state c%0d rsv=%b busy=%b exp rsv=%b busy=%b", c, cdb_rsv, div_busy, e.rsv, e.busy);
      end
      $display("reset c%0d strobes=%b rsv=%b busy=%b", c, strobes(), cdb_rsv, div_busy);
      next_cycle();
    end
    i_rst_n = 1'b1;
    sb.push_back('{strb: 4'b1000, busy: 1'b0, rsv: '0});
    #2;
    e = sb.pop_front();
    checks++;
    if (strobes() !== e.strb || issue_fu !== 2'(FU_DIV)) begin
      errors++;
      $display("FAIL reset_release strobes=%b fu=%0d exp=%b fu=%0d", strobes(), issue_fu, e.strb, FU_DIV);
    end
    $display("release strobes=%b fu=%0d", strobes(), issue_fu);
    next_cycle();
  endtask

  task automatic test_int_stream();
    exp_t e;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_rdy(4'b0001);
      sb.push_back('{strb: 4'b0001, busy: 1'b0, rsv: '0});
      #2;
      e = sb.pop_front();
      checks++;
      if (strobes() !== e.strb || cdb_rsv !== e.rsv || issue_fu !== 2'(FU_INT)) begin
        errors++;
        $display("FAIL int_stream c%0d strobes=%b rsv=%b fu=%0d exp=%b rsv=%b", c, strobes(), cdb_rsv, issue_fu, e.strb, e.rsv);
      end
      $display("int_stream c%0d strobes=%b rsv=%b", c, strobes(), cdb_rsv);
      next_cycle();
    end
  endtask

  task automatic test_mult_int();
    logic [3:0] rdy [5];
    logic [3:0] exp_s [5];
    exp_t e;
    rdy   = '{4'b0101, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_s = '{4'b0100, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_rdy(rdy[c]);
      sb.push_back('{strb: exp_s[c], busy: 1'b0, rsv: '0});
      #2;
      e = sb.pop_front();
      checks++;
      if (strobes() !== e.strb) begin
        errors++;
        $display("FAIL mult_int c%0d strobes=%b exp=%b", c, strobes(), e.strb);
      end
      $display("mult_int c%0d strobes=%b rsv=%b", c, strobes(), cdb_rsv);
      next_cycle();
    end
  endtask

  task automatic test_div_occupancy();
    exp_t e;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      set_rdy(4'b1000);
      sb.push_back('{strb: (c == 0 || c == 7) ? 4'b1000 : 4'b0000,
                     busy: (c >= 1 && c <= 6) ? 1'b1 : (c == 8), rsv: '0});
      #2;
      e = sb.pop_front();
      checks++;
      if (strobes() !== e.strb || div_busy !== e.busy) begin
        errors++;
        $display("FAIL div_occ c%0d strobes=%b busy=%b exp=%b busy=%b", c, strobes(), div_busy, e.strb, e.busy);
      end
      $display("div_occ c%0d strobes=%b busy=%b", c, strobes(), div_busy);
      next_cycle();
    end
  endtask

  task automatic test_div_mult();
    logic [3:0] rdy [5];
    logic [3:0] exp_s [5];
    exp_t e;
    rdy   = '{4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    exp_s = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_rdy(rdy[c]);
      sb.push_back('{strb: exp_s[c], busy: 1'b0, rsv: DL'(1) << (DL - 1 - c)});
      #2;
      e = sb.pop_front();
      checks++;
      if (strobes() !== e.strb) begin
        errors++;
        $display("FAIL div_mult c%0d strobes=%b exp=%b", c, strobes(), e.strb);
      end
      if (c > 0) begin
        checks++;
        if (cdb_rsv !== e.rsv) begin
          errors++;
          $display("FAIL div_mult_rsv c%0d rsv=%b exp=%b", c, cdb_rsv, e.rsv);
        end
      end
      $display("div_mult c%0d strobes=%b rsv=%b", c, strobes(), cdb_rsv);
      next_cycle();
    end
  endtask

  task automatic test_arbitration();
    exp_t e;
    logic [3:0] want;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_rdy(4'b0011);
`ifdef ISSUE_LRU_EN
      want = (c % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      want = 4'b0001;
`endif
      sb.push_back('{strb: want, busy: 1'b0, rsv: '0});
      #2;
      e = sb.pop_front();
      checks++;
      if (strobes() !== e.strb) begin
        errors++;
        $display("FAIL arbitration c%0d strobes=%b exp=%b", c, strobes(), e.strb);
      end
      $display("arbitration c%0d strobes=%b", c, strobes());
      next_cycle();
    end
  endtask

  // Randomized traffic with occasional mid-run reset; expectations from a model that books
  // CDB writes by absolute cycle number.
  task automatic test_back_to_back();
    bit         book[int];
    int         free_at;
    int         t;
    bit         lru;
    logic [3:0] r;
    logic [3:0] s;
    logic [1:0] fu;
    logic       rst_cyc;
    logic       de, me, ie, le;
    exp_t       e;
    do_reset();
    free_at = 0;
    t = 0;
    lru = 1'b0;
    for (int c = 0; c < 300; c++) begin
      r = 4'($urandom_range(0, 15));
      rst_cyc = ($urandom_range(0, 39) == 0);
      i_rst_n = ~rst_cyc;
      set_rdy(r);
      de = r[3] && (t >= free_at) && !book.exists(t + DL);
      me = r[2] && !book.exists(t + ML);
      le = r[1] && !book.exists(t + 1);
      ie = r[0] && !book.exists(t + 1);
      s = 4'b0000;
      if (!rst_cyc) begin
        if (de) s = 4'b1000;
        else if (me) s = 4'b0100;
        else if (ie && le) s = lru ? 4'b0010 : 4'b0001;
        else if (ie) s = 4'b0001;
        else if (le) s = 4'b0010;
      end
      e.strb = s;
      e.busy = (t < free_at);
      for (int k = 0; k < DL; k++) e.rsv[k] = book.exists(t + k + 1);
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      fu = e.strb[3] ? 2'd3 : e.strb[2] ? 2'd2 : e.strb[1] ? 2'd1 : 2'd0;
      checks++;
      if (strobes() !== e.strb || issue_valid !== (e.strb != 0) || issue_fu !== fu) begin
        errors++;
        $display("FAIL rand_issue c%0d rdy=%b strobes=%b valid=%b fu=%0d exp=%b fu=%0d", c, r, strobes(), issue_valid, issue_fu, e.strb, fu);
      end
      checks++;
      if (cdb_rsv !== e.rsv || div_busy !== e.busy) begin
        errors++;
        $display("FAIL rand_state c%0d rsv=%b busy=%b exp rsv=%b busy=%b", c, cdb_rsv, div_busy, e.rsv, e.busy);
      end
      $display("rand c%0d rst=%b rdy=%b strobes=%b rsv=%b busy=%b", c, rst_cyc, r, strobes(), cdb_rsv, div_busy);
      if (rst_cyc) begin
        book.delete();
        free_at = 0;
        lru = 1'b0;
      end else begin
        if (s[3]) begin
          book[t + DL] = 1'b1;
          free_at = t + DL;
        end
        if (s[2]) book[t + ML] = 1'b1;
`ifdef ISSUE_LRU_EN
        if (s[0]) lru = 1'b1;
        if (s[1]) lru = 1'b0;
`endif
      end
      t++;
      next_cycle();
    end
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    set_rdy(4'h0);
    #1;
    test_reset();
    test_int_stream();
    test_mult_int();
    test_div_occupancy();
    test_div_mult();
    test_arbitration();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
